// File: rtl/sseg_capture_if.sv
// Bundle of the observed seven-segment display lines and the reconstructed-frame outputs.
//   sseg  [0:6]  segment lines a..g, active-low (sseg[0] = a)
//   an    [3:0]  digit enables, active-low (an[0] = least significant nibble)
//   num   [15:0] last complete 4-digit frame
//   valid        one-cycle pulse when num is updated
//   err          one-cycle pulse on an illegal accepted pattern
//   stale        level, high while nothing has been captured for TIMEOUT cycles
// master drives the display lines (the display under observation), slave is the capture block.
interface sseg_capture_if;
  logic [0:6]  sseg;
  logic [3:0]  an;
  logic [15:0] num;
  logic        valid;
  logic        err;
  logic        stale;

  modport master (output sseg, an, input num, valid, err, stale);
  modport slave  (input sseg, an, output num, valid, err, stale);
endinterface

// File: rtl/sseg_capture.sv
// Seven-segment display snooper: samples a multiplexed 4-digit display, debounces each scan
// step, decodes the hex glyph and reassembles the 16-bit value shown on the display.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  sseg_capture_if.slave: sseg/an in, num/valid/err/stale out (all registered)
// Parameters:
//   STABLE   consecutive identical samples needed to accept a digit (1..15)
//   TIMEOUT  cycles without a legal capture before stale asserts
module sseg_capture #(
  parameter int unsigned STABLE  = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic           clk,
  input logic           rst,
  sseg_capture_if.slave bus
);

  localparam logic [3:0]         StableC = 4'(STABLE);
  localparam int unsigned        IdleW   = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0]   IdleMax = IdleW'(TIMEOUT);

  // Returns {legal, nibble} for a lit-segment vector ordered {a,b,c,d,e,f,g}.
  function automatic logic [4:0] decode(input logic [6:0] lit);
    logic [4:0] r;
    case (lit)
      7'b1111110: r = {1'b1, 4'h0};
      7'b0110000: r = {1'b1, 4'h1};
      7'b1101101: r = {1'b1, 4'h2};
      7'b1111001: r = {1'b1, 4'h3};
      7'b0110011: r = {1'b1, 4'h4};
      7'b1011011: r = {1'b1, 4'h5};
      7'b1011111: r = {1'b1, 4'h6};
      7'b1110000: r = {1'b1, 4'h7};
      7'b1111111: r = {1'b1, 4'h8};
      7'b1111011: r = {1'b1, 4'h9};
      7'b1110111: r = {1'b1, 4'hA};
      7'b0011111: r = {1'b1, 4'hB};
      7'b1001110: r = {1'b1, 4'hC};
      7'b0111101: r = {1'b1, 4'hD};
      7'b1001111: r = {1'b1, 4'hE};
      7'b1000111: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Sample stage and the sample before it; the run counter compares the two.
  logic [3:0]       an_q, an_prev_q;
  logic [0:6]       sseg_q, sseg_prev_q;
  logic [3:0]       run_q, run_d;
  logic [3:0]       digit_q [4];
  logic [3:0]       mask_q, mask_d;
  logic [15:0]      num_q, num_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             stale_q;

  logic             same;
  logic             accept;
  logic             blank;
  logic [6:0]       lit;
  logic [4:0]       dec;
  logic [1:0]       digit_idx;
  logic             digit_we;
  logic             legal;
  logic [3:0]       mask_set;
  logic [15:0]      frame;

  always_comb begin
    same = (an_q == an_prev_q) && (sseg_q == sseg_prev_q);
    if (!same) begin
      run_d = 4'd1;
    end else if (run_q == StableC) begin
      run_d = run_q;
    end else begin
      run_d = run_q + 4'd1;
    end
    // Fire once when the run first reaches STABLE; a saturated run does not re-fire, but a
    // fresh run with STABLE=1 does.
    accept = (run_d == StableC) && (!same || (run_q != StableC));
  end

  always_comb begin
    blank     = (an_q == 4'hF);
    lit       = ~sseg_q;
    dec       = decode(lit);
    digit_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an_q[i]) digit_idx = 2'(i);
    end
    mask_set = mask_q | (4'b0001 << digit_idx);
    frame    = {digit_q[3], digit_q[2], digit_q[1], digit_q[0]};
    frame[{digit_idx, 2'b00} +: 4] = dec[3:0];

    mask_d   = mask_q;
    num_d    = num_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    digit_we = 1'b0;
    legal    = 1'b0;

    if (accept && !blank) begin
      if (!$onehot(~an_q) || !dec[4]) begin
        err_d  = 1'b1;
        mask_d = 4'b0000;
      end else begin
        legal    = 1'b1;
        digit_we = 1'b1;
        if (mask_set == 4'b1111) begin
          num_d   = frame;
          valid_d = 1'b1;
          mask_d  = 4'b0000;
        end else begin
          mask_d = mask_set;
        end
      end
    end

    if (legal) begin
      idle_d = '0;
    end else if (idle_q == IdleMax) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IdleW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q        <= 4'hF;
      sseg_q      <= 7'b1111111;
      an_prev_q   <= 4'hF;
      sseg_prev_q <= 7'b1111111;
      run_q       <= 4'd0;
      mask_q      <= 4'b0000;
      num_q       <= 16'h0000;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      idle_q      <= '0;
      stale_q     <= 1'b0;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'h0;
    end else begin
      an_q        <= bus.an;
      sseg_q      <= bus.sseg;
      an_prev_q   <= an_q;
      sseg_prev_q <= sseg_q;
      run_q       <= run_d;
      mask_q      <= mask_d;
      num_q       <= num_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      idle_q      <= idle_d;
      stale_q     <= (idle_d == IdleMax);
      if (digit_we) digit_q[digit_idx] <= dec[3:0];
    end
  end

  assign bus.num   = num_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.stale = stale_q;

endmodule
